// File: rtl/flopoco_pkg.sv
// Shared FloPoCo 11-bit float definitions (exp 4, frac 4) for the fmul/fadd
// companion stages: widths, field positions and exception encodings.
package flopoco_pkg;

    localparam int unsigned FP_W   = 11;
    localparam int unsigned EXP_W  = 4;
    localparam int unsigned FRAC_W = 4;
    localparam int unsigned EXP_BIAS = 7;

    // Field positions inside a packed FloPoCo word {exn, sign, exp, frac}
    localparam int unsigned EXN_MSB  = FP_W - 1;
    localparam int unsigned EXN_LSB  = FP_W - 2;
    localparam int unsigned SIGN_BIT = EXP_W + FRAC_W;
    localparam int unsigned EXP_MSB  = EXP_W + FRAC_W - 1;
    localparam int unsigned EXP_LSB  = FRAC_W;
    localparam int unsigned FRAC_MSB = FRAC_W - 1;
    localparam int unsigned FRAC_LSB = 0;

    typedef logic [FP_W-1:0] fp_t;

    typedef enum logic [1:0] {
        EXN_ZERO   = 2'b00,
        EXN_NORMAL = 2'b01,
        EXN_INF    = 2'b10,
        EXN_NAN    = 2'b11
    } exn_e;

    function automatic exn_e exn_of(input fp_t value);
        return exn_e'(value[EXN_MSB:EXN_LSB]);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with a registered head and circular pointers
// that wrap modulo DEPTH (DEPTH need not be a power of two).
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // head is a register: it takes the next stored word on a pop, or the
    // incoming word when the FIFO is (or becomes) otherwise empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
            if (do_pop) begin
                if (count > CW'(1)) begin
                    head <= mem[ptr_inc(rd_ptr)];
                end else if (do_push) begin
                    head <= push_data;
                end
            end else if (empty && do_push) begin
                head <= push_data;
            end
        end
    end

    assert property (@(posedge clk) disable iff (!reset_n) !(push && full && !pop));

endmodule

// File: rtl/fmul_result_collector.sv
// Collects products from a fixed-latency, handshake-free fmul core into a
// FIFO, issuing credits upstream so no product is lost to backpressure.
module fmul_result_collector
    import flopoco_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  R,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP_W-1:0]  out_data,
    output logic [CNT_W-1:0] nan_cnt,
    output logic [CNT_W-1:0] inf_cnt,
    input  logic             clr_cnt
);

    localparam int unsigned RES_W = $clog2(DEPTH + 1);

    logic               fire;
    logic               capture;
    logic               pop;
    logic [LATENCY-1:0] vp;
    logic [RES_W-1:0]   reserved;
    logic [RES_W-1:0]   fifo_count;
    exn_e               cap_exn;

    // A credit is held from issue until the product leaves the FIFO, so the
    // in-flight plus buffered total can never exceed DEPTH.
    assign in_ready  = (reserved < RES_W'(DEPTH));
    assign fire      = in_valid && in_ready;
    assign capture   = vp[LATENCY-1];
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign cap_exn   = exn_of(R);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vp <= '0;
        end else begin
            vp[0] <= fire;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                vp[i] <= vp[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reserved <= '0;
        end else if (fire && !pop) begin
            reserved <= reserved + RES_W'(1);
        end else if (pop && !fire) begin
            reserved <= reserved - RES_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nan_cnt <= '0;
            inf_cnt <= '0;
        end else if (clr_cnt) begin
            nan_cnt <= '0;
            inf_cnt <= '0;
        end else if (capture) begin
            if (cap_exn == EXN_NAN && nan_cnt != '1) begin
                nan_cnt <= nan_cnt + CNT_W'(1);
            end
            if (cap_exn == EXN_INF && inf_cnt != '1) begin
                inf_cnt <= inf_cnt + CNT_W'(1);
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH (FP_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (capture),
        .push_data (R),
        .pop       (pop),
        .head      (out_data),
        .count     (fifo_count)
    );

endmodule

// File: doc/fmul_result_collector.md
Name: fmul_result_collector

Overview:
- Downstream companion to the flopoco_fmul_4_4 core: 11-bit FloPoCo floating-point product, exp 4, frac 4, fixed pipeline depth, no handshake.
- Tracks which fmul issue cycles carry valid operands and captures the matching products R.
- Buffers captured products in a small FIFO with a valid/ready output.
- Uses credits to tell the upstream operand source when it may issue, so a product is never lost to backpressure.

Parameters:
- LATENCY, 2: fmul pipeline depth in clock edges from operand sample to R sample; must equal the instantiated core's depth; >=1.
- DEPTH, 4: result FIFO entries; >=2; full throughput requires DEPTH >= LATENCY+1.
- CNT_W, 16: width of the exception event counters.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream has X/Y on the fmul inputs this cycle.
- in_ready  out  1  credit available; issue fires when in_valid && in_ready.
- R  in  11  product from the fmul core.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_data  out  11  FIFO head product.
- nan_cnt  out  CNT_W  count of captured products with exn=11.
- inf_cnt  out  CNT_W  count of captured products with exn=10.
- clr_cnt  in  1  synchronous clear of both counters.

Behaviour:
- Format: R[10:9] exn (00 zero, 01 normal, 10 inf, 11 NaN), R[8] sign, R[7:4] exp (bias 7), R[3:0] frac. The block never modifies data.
- Reset (reset_n low, asynchronous): valid pipe all 0, FIFO empty, credit counter 0, counters 0. Outputs: in_ready=1, out_valid=0, out_data=0.
- Reset mid-operation drops all in-flight and buffered products; nothing is emitted for them after release.
- fire = in_valid && in_ready.
- Valid pipe is LATENCY bits. vp[0] <= fire; vp[i] <= vp[i-1].
- Capture condition: vp[LATENCY-1] high before edge e. At edge e, R is written into the FIFO tail.
  - An issue fired at edge k is therefore captured at edge k+LATENCY.
  - out_valid rises after that edge when the FIFO was empty.
- FIFO:
  - First-word-fall-through; out_data is the registered head.
  - out_valid = (occupancy != 0).
  - pop = out_valid && out_ready.
  - Circular read/write pointers wrap modulo DEPTH.
  - Capture and pop in the same edge: occupancy unchanged, both pointers advance.
  - Capture into an empty FIFO: no same-edge bypass; the new word is visible the next cycle.
  - out_data holds its last value when the FIFO is empty.
- Credits:
  - reserved counter, width clog2(DEPTH+1): +1 on fire, -1 on pop, unchanged if both.
  - in_ready = (reserved < DEPTH), combinational from the register.
  - Overflow is structurally impossible. Capturing while full is an assertion failure in simulation.
- Counters:
  - On capture, nan_cnt increments if R[10:9]==11; inf_cnt increments if R[10:9]==10.
  - Both saturate at all-ones.
  - clr_cnt has priority over an increment in the same edge.
- in_valid with in_ready=0: no fire and no pipe bit set. Upstream must hold its operands; the fmul output for that cycle is ignored.

Decomposition:
- Shared package flopoco_pkg:
  - FP_W=11, EXP_W=4, FRAC_W=4.
  - Exn encodings EXN_ZERO/EXN_NORMAL/EXN_INF/EXN_NAN.
  - Field-slice constants.
- One sub-module: sync_fifo_fwft (parameter WIDTH, DEPTH; push, pop, head, count), reusable by the other fmul/fadd stages.
- Valid pipe, credits and counters stay in the top module.

Test Plan:
- Single issue: in_valid=1 for one cycle at edge k with 2.0×3.0, fmul R=01010011000 → out_valid rises after edge k+2, out_data=01010011000 (6.0), one beat only, reserved returns to 0 after pop.
- Streaming with out_ready=1 and in_valid held for 20 cycles → in_ready stays 1 throughout, 20 results in order, no bubbles after the first.
- Backpressure with out_ready=0 and in_valid=1 → exactly DEPTH=4 fires, then in_ready=0. Raise out_ready → 4 results in issue order, then in_ready returns.
- Exceptions: capture R=11000000000 twice and 10000000000 once → nan_cnt=2, inf_cnt=1. clr_cnt on the same edge as a NaN capture → nan_cnt=0.
- Reset mid-flight: 2 in pipe, 2 in FIFO, pulse reset_n low between edges → immediately out_valid=0, in_ready=1. After release, no stale outputs; next issue behaves as the single-issue case.
- Pointer wrap: 3×DEPTH push/pop with alternating out_ready → data integrity across wrap, capture and pop on the same edge leave occupancy constant.
